multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle NITCRISC24 core. Decodes the IR opcode, sequences
//  fetch/decode/execute/memory/writeback, and drives datapath selects, write enables and
//  the 2-bit alu_op consumed by the ALU-control decoder (00 add, 01 sub, 1x funct-coded).
//  Stalls on a memory-ready handshake; traps illegal opcodes.
// PARAMETERS
//  OP_W      4   opcode field width (instr opcode bits)
//  CNT_W     32  width of performance counters (CTRL_PERF_CNT_EN only)
// PORTS
//  clk            in   1      single system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  opcode         in   OP_W   IR opcode field (valid from DECODE onward)
//  zero           in   1      ALU zero flag (used in BEQ)
//  mem_ready      in   1      memory access completes this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load qualified by zero (branch)
//  i_or_d         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read       out  1      memory read request (held until mem_ready)
//  mem_write      out  1      memory write request (held until mem_ready)
//  ir_write       out  1      IR load (asserted only with mem_ready in FETCH)
//  mem_to_reg     out  1      RF write data: 0=ALUOut, 1=MDR
//  reg_write      out  1      RF write enable
//  reg_dst        out  1      RF dest: 0=rt, 1=rd
//  alu_src_a      out  1      0=PC, 1=A reg
//  alu_src_b      out  2      00=B, 01=const 1, 10=sign-ext imm, 11=sign-ext imm (branch)
//  alu_op         out  2      to ALU-control: 00 add, 01 sub, 10 R-type funct
//  pc_source      out  2      00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1      sticky: unsupported opcode decoded
//  state_o        out  4      current state encoding (debug)
// BEHAVIOUR
//  - Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 J; all others illegal.
//  - States (enc): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXE 6, RWB 7,
//    BEQ 8, JMP 9, TRAP 10. Moore outputs, registered state; unlisted outputs = 0.
//  - FETCH: mem_read=1,i_or_d=0,alu_src_a=0,alu_src_b=01,alu_op=00,pc_source=00. Stay while
//    !mem_ready; when mem_ready: ir_write=1,pc_write=1 (PC+1), -> DECODE.
//  - DECODE: alu_src_a=0,alu_src_b=11,alu_op=00 (branch target to ALUOut). Next by opcode:
//    LW/SW->MEMADR, R->REXE, BEQ->BEQ, J->JMP, else ->TRAP.
//  - MEMADR: alu_src_a=1,alu_src_b=10,alu_op=00; LW->MEMRD, SW->MEMWR.
//  - MEMRD: mem_read=1,i_or_d=1; hold until mem_ready, then ->MEMWB.
//  - MEMWB: reg_write=1,mem_to_reg=1,reg_dst=0; ->FETCH.
//  - MEMWR: mem_write=1,i_or_d=1; hold until mem_ready, then ->FETCH.
//  - REXE: alu_src_a=1,alu_src_b=00,alu_op=10; ->RWB. RWB: reg_write=1,reg_dst=1; ->FETCH.
//  - BEQ: alu_src_a=1,alu_src_b=00,alu_op=01,pc_source=01,pc_write_cond=1; ->FETCH.
//  - JMP: pc_write=1,pc_source=10; ->FETCH.
//  - TRAP: all enables 0, illegal_op=1; stays in TRAP until reset.
//  - Cycles/instr with mem_ready tied 1: R=4, LW=5, SW=4, BEQ=3, J=3. Each mem wait adds 1.
//  - Mem handshake: mem_read/mem_write stay high and address selects stable while waiting;
//    no write enable (ir_write, reg_write, pc_write) fires before mem_ready.
//  - Reset (async, any state incl. mid-wait): state=FETCH, illegal_op=0; all outputs take
//    FETCH values immediately (mem_read=1, others 0 except selects as above).
//  - Never mem_read and mem_write together; never reg_write in same cycle as mem_write.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds ports cycle_cnt[CNT_W] (+1 every cycle outside TRAP) and
//  instr_cnt[CNT_W] (+1 on each transition into FETCH from a final state); both reset 0,
//  wrap modulo 2^CNT_W. Undefined: ports and counters absent; FSM behaviour identical.
// TESTING
//  LW (0001), mem_ready=1 -> states 0,1,2,3,4,0; reg_write+mem_to_reg=1 in cycle 5 only.
//  SW, mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, i_or_d=1, then FETCH.
//  BEQ with zero=1 -> cycle 3: pc_write_cond=1, alu_op=01, pc_source=01; zero=0 same ctrl.
//  R-type -> REXE alu_op=10, RWB reg_write=1 reg_dst=1; 4 cycles total.
//  Opcode 1111 -> DECODE->TRAP, illegal_op=1 sticky, no enables until rst_n low.
//  rst_n low during MEMRD wait -> immediate FETCH, illegal_op=0; perf counters (if EN) = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle NITCRISC24 core: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            reg_dst,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_source,
   output logic            illegal_op,
   output logic [3:0]      state_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      REXE   = 4'd6,
      RWB    = 4'd7,
      BEQ    = 4'd8,
      JMP    = 4'd9,
      TRAP   = 4'd10
   } stateE;

   localparam logic [OP_W-1:0] OP_R   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LW  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SW  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_BEQ = OP_W'(3);
   localparam logic [OP_W-1:0] OP_J   = OP_W'(4);

   stateE state, nextState;

   // The branch zero flag is combined with pc_write_cond in the datapath, not here.
   logic unusedZero;
   assign unusedZero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= nextState;
   end

   always_comb begin
      nextState     = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      unique case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // Qualified by rst_n so no write enable leaks out while reset is held.
            ir_write  = mem_ready && rst_n;
            pc_write  = mem_ready && rst_n;
            if (mem_ready) nextState = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            unique case (opcode)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_R:         nextState = REXE;
               OP_BEQ:       nextState = BEQ;
               OP_J:         nextState = JMP;
               default:      nextState = TRAP;
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) nextState = MEMWB;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            nextState  = FETCH;
         end
         MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) nextState = FETCH;
         end
         REXE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nextState = RWB;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            nextState = FETCH;
         end
         BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
            nextState     = FETCH;
         end
         JMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            nextState = FETCH;
         end
         TRAP:    nextState = TRAP;
         default: nextState = FETCH;
      endcase
   end

   // TRAP is only left through reset, so the state itself is the sticky flag.
   assign illegal_op = (state == TRAP);
   assign state_o    = state;

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (state != TRAP) cycle_cnt <= cycle_cnt + 1'b1;
         if (nextState == FETCH && state != FETCH) instr_cnt <= instr_cnt + 1'b1;
      end
   end
`else
   localparam int unusedCntW = CNT_W;
`endif

endmodule
